alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Instruction issue/writeback sequencer that drives the 32-bit ALU's operand and opcode inputs and collects its registered result. It accepts 32-bit instruction words over a valid/ready handshake and reads operands from an internal 8x32 register file. It issues the operation to the ALU, waits out the ALU's one-clock latency, and writes the result back. It sits between the instruction source (fetch stage or testbench) and the ALU.

Parameters:
NREGS, 8, number of architectural registers; addresses are 3 bits; r0 reads 0 and ignores writes
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  clock; all state updates on the rising edge
RST  input  1  reset, synchronous, active-low (RST==0 resets on the clk edge)
instr_valid  input  1  instruction word present
instr  input  32  [31:28] opcode, [27:25] rd, [24:22] rs1, [21:19] rs2, [15:0] imm16
instr_ready  output  1  controller can accept an instruction this cycle
alu_src  output  32  ALU operand 1 (registered)
alu_src2  output  32  ALU operand 2 (registered)
alu_opcode  output  4  ALU opcode (registered); 4'b0000 when idle
alu_result  input  32  ALU registered result
done  output  1  one-cycle pulse: an instruction retired
err  output  1  one-cycle pulse with done: the retired instruction was illegal
retire_cnt  output  CNT_W  retired-instruction count, wraps modulo 2^CNT_W
dbg_addr  input  3  debug register-file read address
dbg_data  output  32  combinational read of reg[dbg_addr]; 0 for r0

Behaviour:
- Opcode classes: 0000 NOP; 0001 LOADI (rd <= zero-extended imm16); 0111 ADD, 1000 SUB, 1001 AND, 1010 OR, 1011 XOR, 1100 SHROL, 1101 SHROR are ALU ops; all other codes are illegal.
- FSM states: IDLE, ISSUE, WB. instr_ready = 1 only in IDLE. An instruction is accepted on an edge where state is IDLE and instr_valid is 1.
- Accepting an ALU op: at the accept edge, alu_src <= reg[rs1], alu_src2 <= reg[rs2], alu_opcode <= opcode; state goes to ISSUE.
- ISSUE (1 cycle): the ALU samples its inputs at the end of this cycle. At that edge, alu_opcode <= 0000 and state goes to WB. alu_src and alu_src2 hold their values.
- WB (1 cycle): alu_result is valid. At the end of WB, reg[rd] <= alu_result (suppressed when rd==0), done <= 1, and state goes to IDLE.
- ALU-op timing: accept edge -> 2 cycles -> write edge. done is high in the cycle after the write edge, and that cycle is IDLE (ready=1). Back-to-back throughput is 1 ALU op per 3 cycles.
- Dependency on the previous instruction: an instruction accepted in the done cycle reads the already-written register file. No bypass is needed.
- NOP, LOADI and illegal opcodes complete at the accept edge and the state stays IDLE. LOADI writes reg[rd] at that edge (suppressed for rd==0). done pulses in the next cycle. Illegal opcodes also pulse err with done and write nothing. ALU outputs are unchanged.
- done and err are registered, high for exactly 1 cycle per retirement. retire_cnt increments by 1 per done, illegal included, and wraps from all-ones to 0.
- alu_opcode is 0000 in every cycle except ISSUE and the cycle it is loaded for. The ALU holds its result for 0000, so the ALU is never re-triggered.
- Reset (RST==0 at an edge, in any state including mid-operation): state <= IDLE; all registers <= 0; alu_src, alu_src2, alu_opcode, done, err and retire_cnt <= 0. An in-flight instruction is dropped with no writeback and no done. During reset cycles instr_ready reads 1, but no instruction is accepted.
- Reads of r0 return 0 on both the operand path and dbg_data.

Test Plan:
- LOADI r1=0x0005, LOADI r2=0x0003, then ADD r3,r1,r2 -> alu_opcode=0111 with src=5, src2=3 for one cycle; dbg r3=8; done pulses 3 cycles after the ADD accept; retire_cnt=3.
- With r1=5, r2=3, issue SUB r4,r1,r2 then XOR r5,r4,r1 back-to-back, instr_valid held high -> r4=2, r5=7; instr_ready low for exactly 2 cycles per op; the second op reads the written r4.
- LOADI r0=0xFFFF, then ADD r0,r1,r2 -> dbg r0=0; done pulses twice; err stays 0.
- Opcode 0011 -> err and done pulse together 1 cycle after accept; no register changes; alu_opcode stays 0000.
- ADD accepted, RST=0 asserted during ISSUE -> no writeback, no done; all regs, retire_cnt and alu_* are 0; instr_ready=1 after RST returns high.
- Preload retire_cnt to 0xFFFF via 65535 NOPs, then 1 more NOP -> retire_cnt=0x0000.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_ctrl_if
//  Description : Signal bundle between the issue controller, its instruction
//                source, the ALU, and status/debug observers.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_issue_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic [31:0]      instr;
    logic             instr_ready;
    logic [31:0]      alu_src;
    logic [31:0]      alu_src2;
    logic [3:0]       alu_opcode;
    logic [31:0]      alu_result;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] retire_cnt;
    logic [2:0]       dbg_addr;
    logic [31:0]      dbg_data;

    // Instruction source / ALU / observer side
    modport master (
        output instr_valid, instr, alu_result, dbg_addr,
        input  instr_ready, alu_src, alu_src2, alu_opcode,
               done, err, retire_cnt, dbg_data
    );

    // Issue controller side
    modport slave (
        input  instr_valid, instr, alu_result, dbg_addr,
        output instr_ready, alu_src, alu_src2, alu_opcode,
               done, err, retire_cnt, dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_ctrl
//  Description : Issue/writeback sequencer for a one-cycle-latency 32-bit ALU.
//                Accepts instruction words, reads operands from an internal
//                register file, issues to the ALU and writes results back.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int NREGS = 8,
    parameter int CNT_W = 16
) (
    input  wire logic         clk,
    input  wire logic         RST,
    alu_issue_ctrl_if.slave   bus_io
);

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_LOADI = 4'b0001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2
    } state_t;

    state_t           state_q;
    logic [31:0]      regs_q [NREGS];
    logic [31:0]      alu_src_q;
    logic [31:0]      alu_src2_q;
    logic [3:0]       alu_opcode_q;
    logic [2:0]       wb_rd_q;
    logic             done_q;
    logic             err_q;
    logic [CNT_W-1:0] retire_cnt_q;

    logic [3:0]  dec_op;
    logic [2:0]  dec_rd;
    logic [2:0]  dec_rs1;
    logic [2:0]  dec_rs2;
    logic [15:0] dec_imm;
    logic        dec_is_alu;
    logic        dec_is_nop;
    logic        dec_is_loadi;
    logic [31:0] rd_op1;
    logic [31:0] rd_op2;
    logic        unused_instr_bits;

    // Field extraction, opcode classification and r0-aware operand reads
    always_comb begin
        dec_op       = bus_io.instr[31:28];
        dec_rd       = bus_io.instr[27:25];
        dec_rs1      = bus_io.instr[24:22];
        dec_rs2      = bus_io.instr[21:19];
        dec_imm      = bus_io.instr[15:0];
        dec_is_nop   = (dec_op == OP_NOP);
        dec_is_loadi = (dec_op == OP_LOADI);
        dec_is_alu   = (dec_op >= 4'b0111) && (dec_op <= 4'b1101);
        rd_op1       = (dec_rs1 == 3'd0) ? 32'h0 : regs_q[dec_rs1];
        rd_op2       = (dec_rs2 == 3'd0) ? 32'h0 : regs_q[dec_rs2];
    end

    assign unused_instr_bits = ^bus_io.instr[18:16];

    // Sequencer: accept in IDLE, hold one ISSUE cycle for the ALU, write back in WB
    always_ff @(posedge clk) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            alu_src_q    <= '0;
            alu_src2_q   <= '0;
            alu_opcode_q <= '0;
            wb_rd_q      <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus_io.instr_valid) begin
                        if (dec_is_alu) begin
                            alu_src_q    <= rd_op1;
                            alu_src2_q   <= rd_op2;
                            alu_opcode_q <= dec_op;
                            wb_rd_q      <= dec_rd;
                            state_q      <= S_ISSUE;
                        end else begin
                            // NOP, LOADI and illegal codes all retire immediately
                            done_q       <= 1'b1;
                            retire_cnt_q <= retire_cnt_q + CNT_W'(1);
                            if (dec_is_loadi && (dec_rd != 3'd0))
                                regs_q[dec_rd] <= {16'h0000, dec_imm};
                            if (!dec_is_nop && !dec_is_loadi)
                                err_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    // ALU captures operands at this edge; drop opcode so it holds
                    alu_opcode_q <= OP_NOP;
                    state_q      <= S_WB;
                end
                S_WB: begin
                    if (wb_rd_q != 3'd0)
                        regs_q[wb_rd_q] <= bus_io.alu_result;
                    done_q       <= 1'b1;
                    retire_cnt_q <= retire_cnt_q + CNT_W'(1);
                    state_q      <= S_IDLE;
                end
                default: begin
                    alu_opcode_q <= OP_NOP;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_io.instr_ready = (state_q == S_IDLE);
    assign bus_io.alu_src     = alu_src_q;
    assign bus_io.alu_src2    = alu_src2_q;
    assign bus_io.alu_opcode  = alu_opcode_q;
    assign bus_io.done        = done_q;
    assign bus_io.err         = err_q;
    assign bus_io.retire_cnt  = retire_cnt_q;
    assign bus_io.dbg_data    = (bus_io.dbg_addr == 3'd0) ? 32'h0 : regs_q[bus_io.dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_ctrl
//  Description : Directed self-checking bench for alu_issue_ctrl with a
//                behavioural one-cycle-latency ALU.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

    logic clk;
    logic RST;
    int   checks;
    int   errors;

    alu_issue_ctrl_if #(.CNT_W(16)) bif ();

    alu_issue_ctrl #(.NREGS(8), .CNT_W(16)) dut (
        .clk    (clk),
        .RST    (RST),
        .bus_io (bif.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Behavioural ALU: registered result, holds when opcode is 0000
    always @(posedge clk) begin
        if (bif.alu_opcode != 4'h0) begin
            case (bif.alu_opcode)
                4'b0111: bif.alu_result <= bif.alu_src + bif.alu_src2;
                4'b1000: bif.alu_result <= bif.alu_src - bif.alu_src2;
                4'b1001: bif.alu_result <= bif.alu_src & bif.alu_src2;
                4'b1010: bif.alu_result <= bif.alu_src | bif.alu_src2;
                4'b1011: bif.alu_result <= bif.alu_src ^ bif.alu_src2;
                default: bif.alu_result <= 32'h0;
            endcase
        end
    end

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic [15:0] imm);
        return {op, rd, rs1, rs2, 3'b000, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic dbg_check(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        bif.dbg_addr = addr;
        #1;
        check(tag, bif.dbg_data, exp);
    endtask

    // Present one instruction for exactly one accept edge
    task automatic send(input logic [31:0] word);
        bif.instr_valid = 1'b1;
        bif.instr       = word;
        tick();
        bif.instr_valid = 1'b0;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        RST             = 1'b0;
        bif.instr_valid = 1'b0;
        bif.instr       = 32'h0;
        bif.dbg_addr    = 3'd0;

        // Reset state
        tick();
        tick();
        check("rst_ready",  {31'h0, bif.instr_ready}, 32'h1);
        check("rst_opcode", {28'h0, bif.alu_opcode}, 32'h0);
        check("rst_cnt",    {16'h0, bif.retire_cnt}, 32'h0);
        check("rst_done",   {31'h0, bif.done}, 32'h0);
        RST = 1'b1;
        tick();

        // LOADI r1=5, LOADI r2=3, ADD r3,r1,r2
        send(mk(4'b0001, 3'd1, 3'd0, 3'd0, 16'h0005));
        check("ldi1_done", {31'h0, bif.done}, 32'h1);
        check("ldi1_err",  {31'h0, bif.err}, 32'h0);
        dbg_check("ldi1_r1", 3'd1, 32'h5);
        send(mk(4'b0001, 3'd2, 3'd0, 3'd0, 16'h0003));
        dbg_check("ldi2_r2", 3'd2, 32'h3);
        send(mk(4'b0111, 3'd3, 3'd1, 3'd2, 16'h0));
        check("add_opcode", {28'h0, bif.alu_opcode}, 32'h7);
        check("add_src",    bif.alu_src, 32'h5);
        check("add_src2",   bif.alu_src2, 32'h3);
        check("add_ready0", {31'h0, bif.instr_ready}, 32'h0);
        check("add_done0",  {31'h0, bif.done}, 32'h0);
        tick();
        check("add_wb_opcode", {28'h0, bif.alu_opcode}, 32'h0);
        check("add_wb_ready",  {31'h0, bif.instr_ready}, 32'h0);
        check("add_wb_done",   {31'h0, bif.done}, 32'h0);
        tick();
        check("add_done",  {31'h0, bif.done}, 32'h1);
        check("add_ready", {31'h0, bif.instr_ready}, 32'h1);
        dbg_check("add_r3", 3'd3, 32'h8);
        tick();
        check("add_done_pulse", {31'h0, bif.done}, 32'h0);
        check("cnt_3", {16'h0, bif.retire_cnt}, 32'h3);

        // SUB r4,r1,r2 then XOR r5,r4,r1 with valid held high
        bif.instr_valid = 1'b1;
        bif.instr       = mk(4'b1000, 3'd4, 3'd1, 3'd2, 16'h0);
        tick();
        bif.instr = mk(4'b1011, 3'd5, 3'd4, 3'd1, 16'h0);
        check("b2b_sub_rdy_a", {31'h0, bif.instr_ready}, 32'h0);
        tick();
        check("b2b_sub_rdy_b", {31'h0, bif.instr_ready}, 32'h0);
        tick();
        check("b2b_sub_rdy_c", {31'h0, bif.instr_ready}, 32'h1);
        check("b2b_sub_done",  {31'h0, bif.done}, 32'h1);
        dbg_check("b2b_r4", 3'd4, 32'h2);
        tick();
        bif.instr_valid = 1'b0;
        check("b2b_xor_src",   bif.alu_src, 32'h2);
        check("b2b_xor_rdy_a", {31'h0, bif.instr_ready}, 32'h0);
        tick();
        check("b2b_xor_rdy_b", {31'h0, bif.instr_ready}, 32'h0);
        tick();
        check("b2b_xor_done", {31'h0, bif.done}, 32'h1);
        dbg_check("b2b_r5", 3'd5, 32'h7);

        // Writes to r0 are ignored
        send(mk(4'b0001, 3'd0, 3'd0, 3'd0, 16'hFFFF));
        check("r0_ldi_done", {31'h0, bif.done}, 32'h1);
        check("r0_ldi_err",  {31'h0, bif.err}, 32'h0);
        dbg_check("r0_ldi_val", 3'd0, 32'h0);
        send(mk(4'b0111, 3'd0, 3'd1, 3'd2, 16'h0));
        tick();
        tick();
        check("r0_add_done", {31'h0, bif.done}, 32'h1);
        check("r0_add_err",  {31'h0, bif.err}, 32'h0);
        dbg_check("r0_add_val", 3'd0, 32'h0);
        tick();
        check("cnt_7", {16'h0, bif.retire_cnt}, 32'h7);

        // Illegal opcode 0011
        send(mk(4'b0011, 3'd1, 3'd2, 3'd2, 16'h1234));
        check("ill_done",   {31'h0, bif.done}, 32'h1);
        check("ill_err",    {31'h0, bif.err}, 32'h1);
        check("ill_opcode", {28'h0, bif.alu_opcode}, 32'h0);
        check("ill_ready",  {31'h0, bif.instr_ready}, 32'h1);
        dbg_check("ill_r1", 3'd1, 32'h5);
        tick();
        check("ill_err_pulse", {31'h0, bif.err}, 32'h0);
        check("cnt_8", {16'h0, bif.retire_cnt}, 32'h8);

        // Reset during ISSUE drops the in-flight ADD
        send(mk(4'b0111, 3'd6, 3'd1, 3'd2, 16'h0));
        RST = 1'b0;
        tick();
        check("mid_rst_opcode", {28'h0, bif.alu_opcode}, 32'h0);
        check("mid_rst_src",    bif.alu_src, 32'h0);
        check("mid_rst_src2",   bif.alu_src2, 32'h0);
        check("mid_rst_cnt",    {16'h0, bif.retire_cnt}, 32'h0);
        check("mid_rst_done",   {31'h0, bif.done}, 32'h0);
        check("mid_rst_ready",  {31'h0, bif.instr_ready}, 32'h1);
        bif.instr_valid = 1'b1;
        bif.instr       = mk(4'b0001, 3'd1, 3'd0, 3'd0, 16'h00AA);
        tick();
        bif.instr_valid = 1'b0;
        check("rst_noaccept_done", {31'h0, bif.done}, 32'h0);
        for (int i = 1; i < 8; i++) dbg_check("mid_rst_reg", 3'(i), 32'h0);
        RST = 1'b1;
        tick();
        check("post_rst_ready", {31'h0, bif.instr_ready}, 32'h1);
        check("post_rst_done",  {31'h0, bif.done}, 32'h0);
        tick();
        check("post_rst_done2", {31'h0, bif.done}, 32'h0);
        dbg_check("post_rst_r6", 3'd6, 32'h0);

        // Counter wrap: 65535 NOPs then one more
        bif.instr_valid = 1'b1;
        bif.instr       = mk(4'b0000, 3'd0, 3'd0, 3'd0, 16'h0);
        for (int n = 0; n < 65535; n++) tick();
        bif.instr_valid = 1'b0;
        tick();
        check("cnt_ffff", {16'h0, bif.retire_cnt}, 32'h0000FFFF);
        send(mk(4'b0000, 3'd0, 3'd0, 3'd0, 16'h0));
        check("nop_done", {31'h0, bif.done}, 32'h1);
        tick();
        check("cnt_wrap", {16'h0, bif.retire_cnt}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
